// File: rtl/brick_pkg.sv
// Shared constants, state encoding and helpers for the brick-alive map.
package brick_pkg;

    localparam int unsigned N_COLS = 20;
    localparam int unsigned N_ROWS = 15;
    localparam int unsigned MAP_W  = N_COLS * N_ROWS;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned PC_W   = 5;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] SPECIAL_L0 = IDX_W'(42);
    localparam logic [IDX_W-1:0] SPECIAL_L1 = IDX_W'(150);
    localparam logic [IDX_W-1:0] SPECIAL_L2 = IDX_W'(299);

    localparam logic [N_COLS-1:0] ROW_FULL  = {N_COLS{1'b1}};
    localparam logic [N_COLS-1:0] ROW_EMPTY = {N_COLS{1'b0}};

    // Number of leading full rows in the level-0 and level-1 patterns
    localparam logic [ROW_W-1:0] L0_ROWS = ROW_W'(5);
    localparam logic [ROW_W-1:0] L1_ROWS = ROW_W'(10);

    // Special brick index for a (clamped) level
    function automatic logic [IDX_W-1:0] special_idx(input logic [1:0] lvl);
        logic [IDX_W-1:0] idx;
        case (lvl)
            2'd0:    idx = SPECIAL_L0;
            2'd1:    idx = SPECIAL_L1;
            default: idx = SPECIAL_L2;
        endcase
        return idx;
    endfunction

    // Count of alive bricks in one row
    function automatic logic [PC_W-1:0] row_popcount(input logic [N_COLS-1:0] r);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_COLS; i++) begin
            c = c + PC_W'(r[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/brick_pattern_rom.sv
// Per-level initial brick pattern, one row at a time.
module brick_pattern_rom
    import brick_pkg::*;
(
    input  logic [1:0]        lvl_i,
    input  logic [ROW_W-1:0]  row_i,
    output logic [N_COLS-1:0] row_c_o
);

    // Levels fill a growing number of leading rows; level 2 fills the whole map
    always_comb begin
        row_c_o = ROW_EMPTY;
        case (lvl_i)
            2'd0:    row_c_o = (row_i < L0_ROWS) ? ROW_FULL : ROW_EMPTY;
            2'd1:    row_c_o = (row_i < L1_ROWS) ? ROW_FULL : ROW_EMPTY;
            default: row_c_o = ROW_FULL;
        endcase
    end

endmodule

// File: rtl/brick_state_mgr.sv
// Brick-alive map owner: level reload, collision clearing, remaining count.
module brick_state_mgr
    import brick_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [1:0]        iLevel,
    input  logic              iLevel_RST,
    input  logic              iHit_valid,
    input  logic [IDX_W-1:0]  iHit_idx,
    output logic [MAP_W-1:0]  oState_flag,
    output logic              oHit_ack,
    output logic              oHit_alive,
    output logic              oSpecial_attacked,
    output logic [CNT_W-1:0]  oBricks_left,
    output logic              oBusy
);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [1:0]         lvl_q, lvl_d;
    logic [MAP_W-1:0]   flag_q, flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic               alive_q, alive_d;
    logic               special_q, special_d;
    logic               rld_prev_q;

    logic               rld_edge;
    logic [N_COLS-1:0]  rom_row;
    logic [IDX_W-1:0]   row_base;
    logic               hit_in_map;
    logic               hit_old;

    brick_pattern_rom u_rom (
        .lvl_i   (lvl_q),
        .row_i   (row_q),
        .row_c_o (rom_row)
    );

    assign rld_edge   = rld_prev_q & ~iLevel_RST;
    assign row_base   = IDX_W'(row_q) * IDX_W'(N_COLS);
    assign hit_in_map = (iHit_idx < IDX_W'(MAP_W));
    assign hit_old    = hit_in_map ? flag_q[iHit_idx] : 1'b0;

    // Next-state and map/count update; a reload edge overrides everything
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        lvl_d     = lvl_q;
        flag_d    = flag_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        alive_d   = 1'b0;
        special_d = 1'b0;
        if (rld_edge) begin
            state_d = ARM;
        end else begin
            case (state_q)
                ARM: begin
                    lvl_d   = (iLevel == 2'd3) ? 2'd2 : iLevel;
                    cnt_d   = '0;
                    row_d   = '0;
                    state_d = LOAD;
                end
                LOAD: begin
                    flag_d[row_base +: N_COLS] = rom_row;
                    cnt_d = cnt_q + CNT_W'(row_popcount(rom_row));
                    if (row_q == ROW_W'(N_ROWS - 1)) begin
                        state_d = RUN;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
                RUN: begin
                    if (iHit_valid) begin
                        ack_d   = 1'b1;
                        alive_d = hit_old;
                        if (hit_old) begin
                            flag_d[iHit_idx] = 1'b0;
                            cnt_d     = cnt_q - CNT_W'(1);
                            special_d = (iHit_idx == special_idx(lvl_q));
                        end
                    end
                end
                default: state_d = ARM;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q    <= ARM;
            row_q      <= '0;
            lvl_q      <= '0;
            flag_q     <= {MAP_W{1'b1}};
            cnt_q      <= CNT_W'(MAP_W);
            ack_q      <= 1'b0;
            alive_q    <= 1'b0;
            special_q  <= 1'b0;
            rld_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            lvl_q      <= lvl_d;
            flag_q     <= flag_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            alive_q    <= alive_d;
            special_q  <= special_d;
            rld_prev_q <= iLevel_RST;
        end
    end

    assign oState_flag       = flag_q;
    assign oBricks_left      = cnt_q;
    assign oHit_ack          = ack_q;
    assign oHit_alive        = alive_q;
    assign oSpecial_attacked = special_q;
    assign oBusy             = (state_q != RUN);

endmodule

// File: tb/tb_brick_state_mgr.sv
// Directed bench for brick_state_mgr.
module tb_brick_state_mgr;

    logic         iCLK = 1'b0;
    logic         iRST;
    logic [1:0]   iLevel;
    logic         iLevel_RST;
    logic         iHit_valid;
    logic [8:0]   iHit_idx;
    logic [299:0] oState_flag;
    logic         oHit_ack;
    logic         oHit_alive;
    logic         oSpecial_attacked;
    logic [8:0]   oBricks_left;
    logic         oBusy;

    int total = 0;
    int bad   = 0;

    logic [299:0] map_l0, map_l1, map_l2, exp_map;

    brick_state_mgr dut (
        .iCLK              (iCLK),
        .iRST              (iRST),
        .iLevel            (iLevel),
        .iLevel_RST        (iLevel_RST),
        .iHit_valid        (iHit_valid),
        .iHit_idx          (iHit_idx),
        .oState_flag       (oState_flag),
        .oHit_ack          (oHit_ack),
        .oHit_alive        (oHit_alive),
        .oSpecial_attacked (oSpecial_attacked),
        .oBricks_left      (oBricks_left),
        .oBusy             (oBusy)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Count cycles with oBusy high, starting from the current (sampled) cycle
    task automatic busy_len(input string tag);
        int n;
        n = 0;
        while (oBusy && n < 100) begin
            n++;
            step();
        end
        chk(tag, 300'(n), 300'(16));
    endtask

    task automatic hit(input logic [8:0] idx);
        iHit_valid = 1'b1;
        iHit_idx   = idx;
        step();
        iHit_valid = 1'b0;
    endtask

    initial begin
        map_l0 = '0; map_l0[99:0]  = '1;
        map_l1 = '0; map_l1[199:0] = '1;
        map_l2 = '1;

        iRST = 1'b0; iLevel = 2'd0; iLevel_RST = 1'b1;
        iHit_valid = 1'b0; iHit_idx = '0;
        step(); step();
        chk("rst_map",   oState_flag, map_l2);
        chk("rst_cnt",   300'(oBricks_left), 300'(300));
        chk("rst_ack",   300'(oHit_ack), 300'(0));
        chk("rst_spec",  300'(oSpecial_attacked), 300'(0));
        chk("rst_busy",  300'(oBusy), 300'(1));

        // Initial level-0 load after reset release
        iRST = 1'b1;
        busy_len("busy_l0");
        chk("l0_map", oState_flag, map_l0);
        chk("l0_cnt", 300'(oBricks_left), 300'(100));

        // Alive hit followed by back-to-back repeat of the same index
        iHit_valid = 1'b1; iHit_idx = 9'd5;
        step();
        chk("h5_ack",   300'(oHit_ack), 300'(1));
        chk("h5_alive", 300'(oHit_alive), 300'(1));
        chk("h5_bit",   300'(oState_flag[5]), 300'(0));
        chk("h5_cnt",   300'(oBricks_left), 300'(99));
        step();
        iHit_valid = 1'b0;
        chk("h5r_ack",   300'(oHit_ack), 300'(1));
        chk("h5r_alive", 300'(oHit_alive), 300'(0));
        chk("h5r_cnt",   300'(oBricks_left), 300'(99));
        step();
        chk("idle_ack", 300'(oHit_ack), 300'(0));

        // Special brick: one-cycle pulse, none on a dead repeat
        hit(9'd42);
        chk("sp_pulse", 300'(oSpecial_attacked), 300'(1));
        chk("sp_cnt",   300'(oBricks_left), 300'(98));
        step();
        chk("sp_end", 300'(oSpecial_attacked), 300'(0));
        hit(9'd42);
        chk("sp2_pulse", 300'(oSpecial_attacked), 300'(0));
        chk("sp2_alive", 300'(oHit_alive), 300'(0));

        // Out-of-map index
        exp_map = map_l0; exp_map[5] = 1'b0; exp_map[42] = 1'b0;
        hit(9'd310);
        chk("oor_ack",   300'(oHit_ack), 300'(1));
        chk("oor_alive", 300'(oHit_alive), 300'(0));
        chk("oor_map",   oState_flag, exp_map);
        chk("oor_cnt",   300'(oBricks_left), 300'(98));

        // Clear every level-0 brick
        for (int i = 0; i < 100; i++) begin
            iHit_valid = 1'b1; iHit_idx = 9'(i);
            step();
        end
        iHit_valid = 1'b0;
        chk("clr_map", oState_flag, 300'(0));
        chk("clr_cnt", 300'(oBricks_left), 300'(0));

        // Reload to level 1
        iLevel = 2'd1; iLevel_RST = 1'b0;
        step();
        iLevel_RST = 1'b1;
        busy_len("busy_l1");
        chk("l1_map", oState_flag, map_l1);
        chk("l1_cnt", 300'(oBricks_left), 300'(200));

        // Level-0 reload interrupted at row 7 by a hit and another reload
        iLevel = 2'd0; iLevel_RST = 1'b0;
        step();
        iLevel_RST = 1'b1;
        step();
        for (int i = 0; i < 7; i++) step();
        iHit_valid = 1'b1; iHit_idx = 9'd150;
        step();
        iHit_valid = 1'b0;
        chk("load_hit_ack", 300'(oHit_ack), 300'(0));
        iLevel_RST = 1'b0;
        step();
        iLevel_RST = 1'b1;
        busy_len("busy_restart");
        chk("rs_map", oState_flag, map_l0);
        chk("rs_cnt", 300'(oBricks_left), 300'(100));

        // Level 3 reload coinciding with a hit: reload wins
        iLevel = 2'd3; iLevel_RST = 1'b0;
        iHit_valid = 1'b1; iHit_idx = 9'd0;
        step();
        iLevel_RST = 1'b1; iHit_valid = 1'b0;
        chk("rld_hit_ack", 300'(oHit_ack), 300'(0));
        busy_len("busy_l3");
        chk("l3_map", oState_flag, map_l2);
        chk("l3_cnt", 300'(oBricks_left), 300'(300));
        hit(9'd299);
        chk("l3_sp",  300'(oSpecial_attacked), 300'(1));
        chk("l3_cnt2", 300'(oBricks_left), 300'(299));

        // Reset in the middle of a level-1 load
        iLevel = 2'd1; iLevel_RST = 1'b0;
        step();
        iLevel_RST = 1'b1;
        for (int i = 0; i < 6; i++) step();
        iRST = 1'b0;
        #1;
        chk("mrst_map",  oState_flag, map_l2);
        chk("mrst_cnt",  300'(oBricks_left), 300'(300));
        chk("mrst_busy", 300'(oBusy), 300'(1));
        iLevel = 2'd0;
        step();
        iRST = 1'b1;
        busy_len("busy_mrst");
        chk("mrst_l0_map", oState_flag, map_l0);
        chk("mrst_l0_cnt", 300'(oBricks_left), 300'(100));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
